operand_fetch_stage: RTL

Instruction-decode / operand-fetch stage of the 8-bit pipelined RISC core. It decodes the 32-bit instruction from IF, drives the read ports of the 8×8 register file, and resolves operands with forwarding from EX and the writeback bypass. It detects load-use hazards and stalls IF for one cycle, then registers decoded fields and operands into the ID/EX pipeline register consumed by the ALU stage.

---
 rtl/operand_fetch_stage.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/operand_fetch_stage.sv
// Decode / operand-fetch stage: decodes IF instructions, forwards from EX and WB, stalls on load-use
// and registers the ID/EX pipeline fields. Optional WB bypass: OPERAND_FETCH_WB_BYPASS_EN.
module operand_fetch_stage #(
  parameter logic [7:0] NOP_OPCODE = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       if_valid,
  input  logic [31:0] if_instr,
  output logic       id_ready,
  input  logic       flush,
  output logic [2:0] rf_read_reg1,
  output logic [2:0] rf_read_reg2,
  input  logic [7:0] rf_read_data1,
  input  logic [7:0] rf_read_data2,
  input  logic       ex_reg_write,
  input  logic       ex_is_load,
  input  logic [2:0] ex_dest,
  input  logic [7:0] ex_result,
  input  logic       wb_reg_write,
  input  logic [2:0] wb_write_reg,
  input  logic [7:0] wb_write_data,
  output logic       id_ex_valid,
  output logic [7:0] id_ex_opcode,
  output logic [2:0] id_ex_dest,
  output logic [7:0] id_ex_op1,
  output logic [7:0] id_ex_op2,
  output logic [7:0] id_ex_imm,
  output logic       id_ex_reg_write,
  output logic       id_ex_is_load,
  output logic [7:0] stall_count
);

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_LWD   = 8'h08;
  localparam logic [7:0] OP_LWI   = 8'h09;
  localparam logic [7:0] OP_SWD   = 8'h0A;
  localparam logic [7:0] OP_SWI   = 8'h0B;

  logic [7:0] opcode_s;
  logic [2:0] dest_s;
  logic [2:0] src1_s;
  logic [2:0] src2_s;
  logic [7:0] imm_s;
  logic       use1_s;
  logic       use2_s;
  logic       reg_write_s;
  logic       is_load_s;
  logic       hazard_s;
  logic       load_s;
  logic [7:0] op1_s;
  logic [7:0] op2_s;

  assign opcode_s     = if_instr[31:24];
  assign dest_s       = if_instr[18:16];
  assign src1_s       = if_instr[10:8];
  assign src2_s       = if_instr[2:0];
  assign imm_s        = if_instr[7:0];
  assign rf_read_reg1 = src1_s;
  assign rf_read_reg2 = src2_s;

`ifndef OPERAND_FETCH_WB_BYPASS_EN
  logic wb_unused_s;
  assign wb_unused_s = &{1'b0, wb_reg_write, wb_write_reg, wb_write_data};
`endif

  // EX result beats the WB bypass; a load in EX has no data yet, so it never forwards.
  function automatic logic [7:0] resolve_operand(
    input logic [2:0] src,
    input logic [7:0] rf_data,
    input logic       ex_wr,
    input logic       ex_ld,
    input logic [2:0] ex_rd,
    input logic [7:0] ex_data,
    input logic       wb_wr,
    input logic [2:0] wb_rd,
    input logic [7:0] wb_data
  );
    logic [7:0] value;
    if (ex_wr && !ex_ld && (ex_rd == src)) begin
      value = ex_data;
`ifdef OPERAND_FETCH_WB_BYPASS_EN
    end else if (wb_wr && (wb_rd == src)) begin
      value = wb_data;
`endif
    end else begin
      value = rf_data;
    end
    return value;
  endfunction

  // Instruction class decode: which sources are read and which control bits are set.
  always_comb begin
    use1_s      = 1'b0;
    use2_s      = 1'b0;
    reg_write_s = 1'b0;
    is_load_s   = 1'b0;
    case (opcode_s)
      OP_LOADI: begin reg_write_s = 1'b1; end
      OP_MOV:   begin use1_s = 1'b1; reg_write_s = 1'b1; end
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        use1_s = 1'b1; use2_s = 1'b1; reg_write_s = 1'b1;
      end
      OP_J:     begin use1_s = 1'b0; end
      OP_BEQ:   begin use1_s = 1'b1; use2_s = 1'b1; end
      OP_LWD:   begin use1_s = 1'b1; reg_write_s = 1'b1; is_load_s = 1'b1; end
      OP_LWI:   begin reg_write_s = 1'b1; is_load_s = 1'b1; end
      OP_SWD:   begin use1_s = 1'b1; use2_s = 1'b1; end
      OP_SWI:   begin use1_s = 1'b1; end
      default:  begin use1_s = 1'b0; end
    endcase
  end

  assign op1_s = resolve_operand(src1_s, rf_read_data1, ex_reg_write, ex_is_load, ex_dest,
                                 ex_result, wb_reg_write, wb_write_reg, wb_write_data);
  assign op2_s = resolve_operand(src2_s, rf_read_data2, ex_reg_write, ex_is_load, ex_dest,
                                 ex_result, wb_reg_write, wb_write_reg, wb_write_data);

  assign hazard_s = if_valid && ex_is_load && ex_reg_write && !flush &&
                    ((use1_s && (ex_dest == src1_s)) || (use2_s && (ex_dest == src2_s)));
  assign id_ready = !hazard_s;
  assign load_s   = if_valid && !flush && !hazard_s;

  // ID/EX pipeline register: decoded instruction or a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_ex_valid     <= 1'b0;
      id_ex_opcode    <= NOP_OPCODE;
      id_ex_dest      <= 3'd0;
      id_ex_op1       <= 8'd0;
      id_ex_op2       <= 8'd0;
      id_ex_imm       <= 8'd0;
      id_ex_reg_write <= 1'b0;
      id_ex_is_load   <= 1'b0;
    end else if (load_s) begin
      id_ex_valid     <= 1'b1;
      id_ex_opcode    <= opcode_s;
      id_ex_dest      <= dest_s;
      id_ex_op1       <= op1_s;
      id_ex_op2       <= op2_s;
      id_ex_imm       <= imm_s;
      id_ex_reg_write <= reg_write_s;
      id_ex_is_load   <= is_load_s;
    end else begin
      id_ex_valid     <= 1'b0;
      id_ex_opcode    <= NOP_OPCODE;
      id_ex_dest      <= 3'd0;
      id_ex_op1       <= 8'd0;
      id_ex_op2       <= 8'd0;
      id_ex_imm       <= 8'd0;
      id_ex_reg_write <= 1'b0;
      id_ex_is_load   <= 1'b0;
    end
  end

  // Saturating load-use stall counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= 8'd0;
    end else if (hazard_s && (stall_count != 8'hFF)) begin
      stall_count <= stall_count + 8'd1;
    end else begin
      stall_count <= stall_count;
    end
  end

endmodule
